imm_extend_pipe: RTL and testbench

Parametrised, registered immediate-generation stage for the decode/execute boundary of the pipelined core.
- Zero- or sign-extends a narrow, mid or full instruction immediate field to DATA_W bits, with an optional left shift.
- Carries a sideband tag alongside each immediate.
- Uses a 2-entry skid buffer with valid/ready handshake, so downstream stalls never drop or duplicate an immediate.
- Flush kills in-flight entries on branch mispredict.

---
 rtl/imm_extend_pipe_pkg.sv | 19 +
 rtl/imm_extend_pipe_if.sv | 28 ++
 rtl/imm_defs.vh | 8 +
 rtl/imm_ext_core.sv | 44 ++++
 rtl/mux2_1.sv | 11 +
 rtl/imm_extend_pipe.sv | 81 ++++++++
 tb/tb_imm_extend_pipe.sv | 233 +++++++++++++++++++++++
 7 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// Shared types and helpers for the immediate-generation stage.
package imm_extend_pipe_pkg;
  `include "imm_defs.vh"

  typedef enum logic [1:0] {
    SZ_NARROW = IMM_SZ_NARROW,
    SZ_MID    = IMM_SZ_MID,
    SZ_FULL   = IMM_SZ_FULL
  } imm_sz_e;

  // Fold the unused 2'b11 code onto full width.
  function automatic imm_sz_e imm_sz_decode(input logic [1:0] bits);
    imm_sz_e sz;
    if (bits[1])                sz = SZ_FULL;
    else if (bits == IMM_SZ_MID) sz = SZ_MID;
    else                        sz = SZ_NARROW;
    return sz;
  endfunction
endpackage

// File: rtl/imm_extend_pipe_if.sv
// Upstream/downstream handshake bundle for the immediate stage.
interface imm_extend_pipe_if #(
  parameter int DATA_W  = 16,
  parameter int FIELD_W = 11,
  parameter int TAG_W   = 4
) ();
  logic               in_valid;
  logic               in_ready;
  logic [FIELD_W-1:0] in_field;
  logic               in_zext;
  logic [1:0]         in_imm_bits;
  logic               in_shl;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_imm;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_field, in_zext, in_imm_bits, in_shl, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag
  );

  modport slave (
    input  in_valid, in_field, in_zext, in_imm_bits, in_shl, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag
  );
endinterface

// File: rtl/imm_defs.vh
// Size-select encodings for the immediate width field (in_imm_bits).
// Bit 1 set means full width regardless of bit 0.
`ifndef IMM_DEFS_VH
`define IMM_DEFS_VH
localparam logic [1:0] IMM_SZ_NARROW = 2'b00;
localparam logic [1:0] IMM_SZ_MID    = 2'b01;
localparam logic [1:0] IMM_SZ_FULL   = 2'b10;
`endif

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: size select, zero/sign fill, optional shift.
module imm_ext_core
  import imm_extend_pipe_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FIELD_W  = 11,
  parameter int NARROW_W = 5,
  parameter int MID_W    = 8,
  parameter int SHL_AMT  = 1
) (
  input  logic [FIELD_W-1:0] i_field,
  input  logic               i_zext,
  input  logic [1:0]         i_imm_bits,
  input  logic               i_shl,
  output logic [DATA_W-1:0]  o_imm
);
  logic signed [DATA_W-1:0] w_n_sx, w_m_sx, w_f_sx;
  logic        [DATA_W-1:0] w_n_zx, w_m_zx, w_f_zx;
  logic        [DATA_W-1:0] w_n, w_m, w_f, w_sz0, w_sz1, w_sh;
  imm_sz_e                  w_sz;
  logic                     w_sel_mid, w_sel_full;

  // Candidate extensions for each size; signed casts replicate the field MSB.
  assign w_n_sx = DATA_W'($signed(i_field[NARROW_W-1:0]));
  assign w_m_sx = DATA_W'($signed(i_field[MID_W-1:0]));
  assign w_f_sx = DATA_W'($signed(i_field));
  assign w_n_zx = DATA_W'(i_field[NARROW_W-1:0]);
  assign w_m_zx = DATA_W'(i_field[MID_W-1:0]);
  assign w_f_zx = DATA_W'(i_field);

  assign w_sz       = imm_sz_decode(i_imm_bits);
  assign w_sel_mid  = (w_sz == SZ_MID);
  assign w_sel_full = (w_sz == SZ_FULL);

  mux2_1 #(.W(DATA_W)) u_mux_n  (.i_a(w_n_sx), .i_b(w_n_zx), .i_sel(i_zext),     .o_y(w_n));
  mux2_1 #(.W(DATA_W)) u_mux_m  (.i_a(w_m_sx), .i_b(w_m_zx), .i_sel(i_zext),     .o_y(w_m));
  mux2_1 #(.W(DATA_W)) u_mux_f  (.i_a(w_f_sx), .i_b(w_f_zx), .i_sel(i_zext),     .o_y(w_f));
  mux2_1 #(.W(DATA_W)) u_mux_s0 (.i_a(w_n),    .i_b(w_m),    .i_sel(w_sel_mid),  .o_y(w_sz0));
  mux2_1 #(.W(DATA_W)) u_mux_s1 (.i_a(w_sz0),  .i_b(w_f),    .i_sel(w_sel_full), .o_y(w_sz1));

  // Bits shifted past the MSB are discarded by the fixed-width shift.
  assign w_sh = w_sz1 << SHL_AMT;
  mux2_1 #(.W(DATA_W)) u_mux_sh (.i_a(w_sz1),  .i_b(w_sh),   .i_sel(i_shl),      .o_y(o_imm));
endmodule

// File: rtl/mux2_1.sv
// Generic W-bit 2:1 multiplexer cell: o_y = i_sel ? i_b : i_a.
module mux2_1 #(
  parameter int W = 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sel,
  output logic [W-1:0] o_y
);
  assign o_y = i_sel ? i_b : i_a;
endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-generation stage with a 2-entry skid buffer.
// M drives the outputs; S catches one push while downstream stalls.
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FIELD_W  = 11,
  parameter int NARROW_W = 5,
  parameter int MID_W    = 8,
  parameter int SHL_AMT  = 1,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  imm_extend_pipe_if.slave bus
);
  logic [DATA_W-1:0] w_ext_p0;
  logic              w_push, w_pop, w_s_load;
  logic              r_m_vld_p1, r_s_vld_p1;
  logic [DATA_W-1:0] r_m_imm_p1, r_s_imm_p1;
  logic [TAG_W-1:0]  r_m_tag_p1, r_s_tag_p1;

  imm_ext_core #(
    .DATA_W  (DATA_W),
    .FIELD_W (FIELD_W),
    .NARROW_W(NARROW_W),
    .MID_W   (MID_W),
    .SHL_AMT (SHL_AMT)
  ) u_core (
    .i_field   (bus.in_field),
    .i_zext    (bus.in_zext),
    .i_imm_bits(bus.in_imm_bits),
    .i_shl     (bus.in_shl),
    .o_imm     (w_ext_p0)
  );

  // in_ready comes straight from the skid flag, so out_ready never reaches it.
  assign w_push   = bus.in_valid & ~r_s_vld_p1;
  assign w_pop    = r_m_vld_p1 & bus.out_ready;
  assign w_s_load = w_push & r_m_vld_p1 & ~w_pop;

  // ---- stage p0 -> p1: main entry and valid flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_vld_p1 <= 1'b0;
      r_s_vld_p1 <= 1'b0;
      r_m_imm_p1 <= '0;
      r_m_tag_p1 <= '0;
    end else if (flush) begin
      r_m_vld_p1 <= 1'b0;
      r_s_vld_p1 <= 1'b0;
    end else if (w_pop && r_s_vld_p1) begin
      r_m_vld_p1 <= 1'b1;
      r_m_imm_p1 <= r_s_imm_p1;
      r_m_tag_p1 <= r_s_tag_p1;
      r_s_vld_p1 <= 1'b0;
    end else if (w_pop || (w_push && !r_m_vld_p1)) begin
      r_m_vld_p1 <= w_push;
      if (w_push) begin
        r_m_imm_p1 <= w_ext_p0;
        r_m_tag_p1 <= bus.in_tag;
      end
    end else if (w_push) begin
      r_s_vld_p1 <= 1'b1;
    end
  end

  // Skid data payload; only its valid flag needs reset.
  always_ff @(posedge clk) begin
    if (w_s_load && !rst && !flush) begin
      r_s_imm_p1 <= w_ext_p0;
      r_s_tag_p1 <= bus.in_tag;
    end
  end

  assign bus.in_ready  = ~r_s_vld_p1;
  assign bus.out_valid = r_m_vld_p1;
  assign bus.out_imm   = r_m_imm_p1;
  assign bus.out_tag   = r_m_tag_p1;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Testbench for imm_extend_pipe: directed vectors plus randomized traffic
// checked against a FIFO scoreboard with an arithmetic extension model.
module tb_imm_extend_pipe;
  localparam int DATA_W   = 16;
  localparam int FIELD_W  = 11;
  localparam int NARROW_W = 5;
  localparam int MID_W    = 8;
  localparam int SHL_AMT  = 1;
  localparam int TAG_W    = 4;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  imm_extend_pipe_if #(.DATA_W(DATA_W), .FIELD_W(FIELD_W), .TAG_W(TAG_W)) u_if ();

  imm_extend_pipe #(
    .DATA_W(DATA_W), .FIELD_W(FIELD_W), .NARROW_W(NARROW_W),
    .MID_W(MID_W), .SHL_AMT(SHL_AMT), .TAG_W(TAG_W)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (u_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  ent_t             sb_q[$];
  logic [TAG_W-1:0] em_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Extension from the arithmetic meaning: take K low bits as an unsigned or
  // two's-complement number, multiply by 2**SHL_AMT, keep DATA_W bits.
  function automatic logic [DATA_W-1:0] ref_ext(input logic [FIELD_W-1:0] f,
                                                input logic [1:0] b,
                                                input logic z, input logic s);
    int     k;
    longint v;
    logic [63:0] r;
    k = b[1] ? FIELD_W : (b[0] ? MID_W : NARROW_W);
    v = longint'(f) % (longint'(1) << k);
    if (!z && v >= (longint'(1) << (k - 1))) v = v - (longint'(1) << k);
    if (s) v = v * (longint'(1) << SHL_AMT);
    r = 64'(v);
    return r[DATA_W-1:0];
  endfunction

  task automatic drive(input logic v, input logic [FIELD_W-1:0] f, input logic [1:0] b,
                       input logic z, input logic s, input logic [TAG_W-1:0] t);
    u_if.in_valid    = v;
    u_if.in_field    = f;
    u_if.in_imm_bits = b;
    u_if.in_zext     = z;
    u_if.in_shl      = s;
    u_if.in_tag      = t;
  endtask

  // Scoreboard: mid-cycle view of what the next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      chk("in_ready",  32'(u_if.in_ready),  32'(sb_q.size() < 2));
      chk("out_valid", 32'(u_if.out_valid), 32'(sb_q.size() > 0));
      if (u_if.out_valid && sb_q.size() > 0) begin
        chk("out_imm", 32'(u_if.out_imm), 32'(sb_q[0].imm));
        chk("out_tag", 32'(u_if.out_tag), 32'(sb_q[0].tag));
      end
      if (flush) begin
        sb_q.delete();
      end else begin
        if (u_if.out_valid && u_if.out_ready && sb_q.size() > 0) begin
          em_q.push_back(u_if.out_tag);
          void'(sb_q.pop_front());
        end
        if (u_if.in_valid && u_if.in_ready)
          sb_q.push_back('{imm: ref_ext(u_if.in_field, u_if.in_imm_bits, u_if.in_zext, u_if.in_shl),
                           tag: u_if.in_tag});
      end
    end
  end

  typedef struct {
    logic [FIELD_W-1:0] f;
    logic [1:0]         b;
    logic               z;
    logic               s;
    logic [DATA_W-1:0]  e;
  } vec_t;

  vec_t vecs[8];
  logic acc;

  initial begin
    vecs[0] = '{11'h010, 2'b00, 1'b0, 1'b0, 16'hFFF0};
    vecs[1] = '{11'h010, 2'b00, 1'b1, 1'b0, 16'h0010};
    vecs[2] = '{11'h4FF, 2'b01, 1'b0, 1'b0, 16'hFFFF};
    vecs[3] = '{11'h4FF, 2'b10, 1'b0, 1'b0, 16'hFCFF};
    vecs[4] = '{11'h4FF, 2'b10, 1'b1, 1'b0, 16'h04FF};
    vecs[5] = '{11'h400, 2'b11, 1'b0, 1'b0, 16'hFC00};
    vecs[6] = '{11'h400, 2'b11, 1'b0, 1'b1, 16'hF800};
    vecs[7] = '{11'h01F, 2'b00, 1'b1, 1'b1, 16'h003E};

    // Reset held two cycles while upstream offers data.
    rst   = 1'b1;
    flush = 1'b0;
    u_if.out_ready = 1'b1;
    drive(1'b1, 11'h7FF, 2'b10, 1'b0, 1'b0, 4'hF);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    u_if.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("rst_in_ready",  32'(u_if.in_ready),  32'd1);
    chk("rst_out_imm",   32'(u_if.out_imm),   32'd0);
    chk("rst_out_tag",   32'(u_if.out_tag),   32'd0);

    // Directed extension vectors, one-cycle latency.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(1'b1, vecs[i].f, vecs[i].b, vecs[i].z, vecs[i].s, TAG_W'(i));
      @(posedge clk); #1;
      u_if.in_valid = 1'b0;
      @(negedge clk);
      chk("dir_valid", 32'(u_if.out_valid), 32'd1);
      chk("dir_imm",   32'(u_if.out_imm),   32'(vecs[i].e));
    end

    // Backpressure: A, B fill M and S; C must wait.
    @(posedge clk); #1;
    u_if.out_ready = 1'b0;
    em_q.delete();
    drive(1'b1, 11'h011, 2'b00, 1'b0, 1'b0, 4'd1);
    @(posedge clk); #1 drive(1'b1, 11'h022, 2'b01, 1'b0, 1'b0, 4'd2);
    @(posedge clk); #1 drive(1'b1, 11'h333, 2'b10, 1'b1, 1'b1, 4'd3);
    @(negedge clk);
    chk("bp_in_ready", 32'(u_if.in_ready), 32'd0);
    chk("bp_out_tag",  32'(u_if.out_tag),  32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("bp_hold_tag", 32'(u_if.out_tag),  32'd1);
    chk("bp_hold_rdy", 32'(u_if.in_ready), 32'd0);
    @(posedge clk); #1 u_if.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc = u_if.in_valid && u_if.in_ready;
      @(posedge clk); #1;
      if (acc) u_if.in_valid = 1'b0;
    end
    chk("bp_count", 32'(em_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < em_q.size()) chk("bp_order", 32'(em_q[i]), 32'(i + 1));

    // Flush with both entries full and a blocked offer.
    u_if.out_ready = 1'b0;
    em_q.delete();
    drive(1'b1, 11'h055, 2'b00, 1'b0, 1'b0, 4'd5);
    @(posedge clk); #1 drive(1'b1, 11'h066, 2'b01, 1'b0, 1'b0, 4'd6);
    @(posedge clk); #1 drive(1'b1, 11'h077, 2'b10, 1'b0, 1'b0, 4'd7);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    u_if.in_valid = 1'b0;
    @(negedge clk);
    chk("fl_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("fl_in_ready",  32'(u_if.in_ready),  32'd1);
    // Flush with only M full and an accepted-looking push in the same cycle.
    @(posedge clk); #1 drive(1'b1, 11'h088, 2'b00, 1'b1, 1'b0, 4'd8);
    @(posedge clk); #1 drive(1'b1, 11'h099, 2'b00, 1'b1, 1'b0, 4'd9);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    @(negedge clk);
    chk("fl2_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("fl2_in_ready",  32'(u_if.in_ready),  32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("fl_emitted", 32'(em_q.size()), 32'd0);

    // Streaming at full rate.
    em_q.delete();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(1'b1, FIELD_W'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), TAG_W'(i));
      @(negedge clk);
      chk("st_in_ready", 32'(u_if.in_ready), 32'd1);
      if (i > 0) chk("st_out_valid", 32'(u_if.out_valid), 32'd1);
    end
    @(posedge clk); #1 u_if.in_valid = 1'b0;
    @(negedge clk);
    chk("st_last_valid", 32'(u_if.out_valid), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("st_count", 32'(em_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < em_q.size()) chk("st_order", 32'(em_q[i]), 32'(i));

    // Randomized traffic with stalls and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      drive(1'($urandom_range(0, 3) != 0), FIELD_W'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), TAG_W'($urandom));
      u_if.out_ready = 1'($urandom_range(0, 2) != 0);
      flush = 1'($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
    chk("drain_valid", 32'(u_if.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
